// File: rtl/tinyqv_qspi_fetch.sv
// QSPI continuous-read (XIP) instruction fetch front end for TinyQV.
// Sends quad address + mode byte, waits out dummy cycles, then streams bytes to the CPU.
module tinyqv_qspi_fetch #(
  parameter int ADDR_BITS    = 24,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_BITS-2:0] instr_addr,
  input  logic                 instr_fetch_restart,
  input  logic                 instr_fetch_stall,
  output logic                 instr_fetch_started,
  output logic                 instr_fetch_stopped,
  output logic [7:0]           instr_data_in,
  output logic                 instr_ready,
  output logic                 spi_clk_out,
  output logic                 spi_cs_n,
  output logic [3:0]           spi_data_out,
  output logic [3:0]           spi_data_oe,
  input  logic [3:0]           spi_data_in
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_CSH} state_t;

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS/4 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 ph_q, ph_d;
  logic                 sck_q, sck_d;
  logic                 cs_n_q, cs_n_d;
  logic [3:0]           oe_q, oe_d;
  logic [3:0]           dout_q, dout_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           hi_q, hi_d;
  logic                 nib_q, nib_d;
  logic [7:0]           data_q, data_d;
  logic                 started_q, started_d;
  logic                 stopped_q, stopped_d;
  logic                 ready_q, ready_d;
  logic [ADDR_BITS-1:0] start_addr;

  assign start_addr = {instr_addr, 1'b0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    oe_d      = oe_q;
    dout_d    = dout_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    nib_d     = nib_q;
    data_d    = data_q;
    started_d = 1'b0;
    stopped_d = 1'b0;
    ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_fetch_restart) begin
          state_d   = S_ADDR;
          cnt_d     = '0;
          ph_d      = 1'b0;
          sck_d     = 1'b0;
          cs_n_d    = 1'b0;
          oe_d      = 4'hF;
          dout_d    = start_addr[ADDR_BITS-1 -: 4];
          addr_d    = {start_addr[ADDR_BITS-5:0], 4'h0};
          started_d = 1'b1;
        end
      end
      S_CSH: begin
        if (cnt_q == 8'd1) state_d = S_IDLE;
        else               cnt_d   = cnt_q + 8'd1;
      end
      default: begin
        // started_q marks the start cycle, where a still-high restart is not an abort
        if (instr_fetch_restart && !started_q) begin
          state_d   = S_CSH;
          cnt_d     = '0;
          cs_n_d    = 1'b1;
          sck_d     = 1'b0;
          oe_d      = 4'h0;
          nib_d     = 1'b0;
          stopped_d = 1'b1;
        end else begin
          ph_d = ~ph_q;
          // ph_q=0 is a rising slot; a stalled slot keeps SCK low for the full 2-cycle period
          if (!ph_q) begin
            sck_d = !(state_q == S_DATA && instr_fetch_stall);
          end else begin
            sck_d = 1'b0;
            if (sck_q) begin
              case (state_q)
                S_ADDR: begin
                  if (cnt_q == ADDR_LAST) begin
                    state_d = S_MODE;
                    cnt_d   = '0;
                    dout_d  = 4'hA;
                  end else begin
                    cnt_d  = cnt_q + 8'd1;
                    dout_d = addr_q[ADDR_BITS-1 -: 4];
                    addr_d = {addr_q[ADDR_BITS-5:0], 4'h0};
                  end
                end
                S_MODE: begin
                  if (cnt_q == 8'd0) begin
                    cnt_d  = 8'd1;
                    dout_d = 4'h0;
                  end else begin
                    state_d = S_DUMMY;
                    cnt_d   = '0;
                    oe_d    = 4'h0;
                  end
                end
                S_DUMMY: begin
                  if (cnt_q == DUMMY_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    nib_d   = 1'b0;
                  end else begin
                    cnt_d = cnt_q + 8'd1;
                  end
                end
                S_DATA: begin
                  if (!nib_q) begin
                    hi_d  = spi_data_in;
                    nib_d = 1'b1;
                  end else begin
                    data_d  = {hi_q, spi_data_in};
                    nib_d   = 1'b0;
                    ready_d = 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ph_q      <= 1'b0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      oe_q      <= 4'h0;
      dout_q    <= 4'h0;
      addr_q    <= '0;
      hi_q      <= 4'h0;
      nib_q     <= 1'b0;
      data_q    <= 8'h00;
      started_q <= 1'b0;
      stopped_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      nib_q     <= nib_d;
      data_q    <= data_d;
      started_q <= started_d;
      stopped_q <= stopped_d;
      ready_q   <= ready_d;
    end
  end

  assign instr_fetch_started = started_q;
  assign instr_fetch_stopped = stopped_q;
  assign instr_data_in       = data_q;
  assign instr_ready         = ready_q;
  assign spi_clk_out         = sck_q;
  assign spi_cs_n            = cs_n_q;
  assign spi_data_out        = dout_q;
  assign spi_data_oe         = oe_q;

endmodule

// File: tb/tb_tinyqv_qspi_fetch.sv
// Bench for tinyqv_qspi_fetch: behavioural XIP flash, byte scoreboard, directed timing
// scenarios followed by randomized fetches with random stalls.
module tb_tinyqv_qspi_fetch;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [22:0] instr_addr = '0;
  logic        restart = 1'b0;
  logic        stall = 1'b0;
  logic        started, stopped, ready, sck, cs_n;
  logic [7:0]  data;
  logic [3:0]  dout, oe;
  logic [3:0]  din = 4'h0;

  tinyqv_qspi_fetch dut (
    .clk(clk), .rstn(rstn), .instr_addr(instr_addr),
    .instr_fetch_restart(restart), .instr_fetch_stall(stall),
    .instr_fetch_started(started), .instr_fetch_stopped(stopped),
    .instr_data_in(data), .instr_ready(ready),
    .spi_clk_out(sck), .spi_cs_n(cs_n), .spi_data_out(dout),
    .spi_data_oe(oe), .spi_data_in(din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;
  int e0 = 0;
  logic [23:0] exp_faddr_q[$];
  logic [7:0]  exp_byte_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: event occurred that should not (t=%0t)", nm, $time);
  endtask

  // Flash contents: fixed bytes at 0x800/0x801, a simple hash elsewhere.
  function automatic logic [7:0] mem(input logic [23:0] a);
    if (a == 24'h000800) return 8'h13;
    if (a == 24'h000801) return 8'h00;
    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // Behavioural flash: sample command on SCK rise, present data after SCK rise.
  int          k = 0;
  logic        prev_sck = 1'b0;
  logic [23:0] fa = '0;
  always @(negedge clk) begin
    if (!rstn || cs_n) begin
      k = 0;
    end else if (sck && !prev_sck) begin
      k++;
      if (k <= 6) begin
        fa = {fa[19:0], dout};
        chk("oe_addr", 32'(oe), 32'hF);
      end else if (k == 7) begin
        chk("mode_hi", 32'(dout), 32'hA);
      end else if (k == 8) begin
        chk("mode_lo", 32'(dout), 32'h0);
        if (exp_faddr_q.size() == 0) bad("unexpected_flash_cmd");
        else chk("flash_addr", 32'(fa), 32'(exp_faddr_q.pop_front()));
      end else if (k == 9) begin
        chk("oe_dummy", 32'(oe), 32'h0);
      end else if (k >= 13) begin
        logic [23:0] ba;
        logic [7:0]  b;
        ba  = fa + 24'((k - 13) / 2);
        b   = mem(ba);
        din = ((k - 13) % 2 == 0) ? b[7:4] : b[3:0];
      end
    end
    prev_sck = sck;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rstn) begin
      if (ready) begin
        if (exp_byte_q.size() == 0) bad("unexpected_ready");
        else chk("byte", 32'(data), 32'(exp_byte_q.pop_front()));
      end
      if (started && stopped) bad("started_and_stopped");
    end
  end

  task automatic push_exp(input logic [22:0] a, input int nb, input bit pushf);
    if (pushf) exp_faddr_q.push_back({a, 1'b0});
    for (int i = 0; i < nb; i++) exp_byte_q.push_back(mem({a, 1'b0} + 24'(i)));
  endtask

  task automatic wait_started(input int max, input bit in_csh, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (started) begin
        n  = i;
        e0 = cyc;
        break;
      end
      if (in_csh) begin
        chk("csh_cs_n", 32'(cs_n), 32'h1);
        chk("csh_no_ready", 32'(ready), 32'h0);
      end
    end
    if (n == 0) bad("started_timeout");
    restart = 1'b0;
    @(negedge clk);
    chk("started_one_cycle", 32'(started), 32'h0);
  endtask

  task automatic start_fetch(input logic [22:0] a, input int nb, input bit pushf);
    int n;
    @(negedge clk);
    instr_addr = a;
    restart    = 1'b1;
    push_exp(a, nb, pushf);
    wait_started(4, 1'b0, n);
    chk("start_latency", 32'(n), 32'd1);
  endtask

  task automatic wait_ready(input int max, input bit rstall, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ready) begin
        at = cyc - e0;
        break;
      end
      if (rstall) stall = ($urandom_range(0, 3) == 0);
    end
    if (at < 0) bad("ready_timeout");
  endtask

  task automatic abort_restart(input int dly, input bit rs, input logic [22:0] a,
                               input int nb, input bit pushf);
    int n;
    repeat (dly) @(negedge clk);
    stall      = 1'b0;
    restart    = 1'b1;
    instr_addr = a;
    if (rs) push_exp(a, nb, pushf);
    @(negedge clk);
    chk("abort_stopped", 32'(stopped), 32'h1);
    chk("abort_cs_n", 32'(cs_n), 32'h1);
    chk("abort_oe", 32'(oe), 32'h0);
    chk("abort_sck", 32'(sck), 32'h0);
    chk("abort_no_ready", 32'(ready), 32'h0);
    if (rs) begin
      wait_started(8, 1'b1, n);
      chk("restart_gap", 32'(n), 32'd3);
    end else begin
      restart = 1'b0;
      @(negedge clk);
      chk("stopped_one_cycle", 32'(stopped), 32'h0);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_cs_n"}, 32'(cs_n), 32'h1);
    chk({nm, "_sck"}, 32'(sck), 32'h0);
    chk({nm, "_oe"}, 32'(oe), 32'h0);
    chk({nm, "_dout"}, 32'(dout), 32'h0);
    chk({nm, "_started"}, 32'(started), 32'h0);
    chk({nm, "_stopped"}, 32'(stopped), 32'h0);
    chk({nm, "_ready"}, 32'(ready), 32'h0);
    chk({nm, "_data"}, 32'(data), 32'h0);
  endtask

  initial begin
    int t, low;
    logic [22:0] a;
    int nb;

    repeat (3) @(negedge clk);
    check_reset("por");
    rstn = 1'b1;

    // First fetch from 0x000400 with fixed timing, then a 5-slot stall.
    start_fetch(23'h000400, 4, 1'b1);
    wait_ready(60, 1'b0, t); chk("b1_time", 32'(t), 32'd28);
    wait_ready(20, 1'b0, t); chk("b2_time", 32'(t), 32'd32);
    stall = 1'b1;
    low   = (sck == 1'b0) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("stall_no_ready", 32'(ready), 32'h0);
      if (!sck) low++;
    end
    stall = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sck) break;
      low++;
    end
    // an unstalled SCK low phase is 1 cycle; five stalled slots add 10
    chk("stall_sck_low_cycles", 32'(low), 32'd11);
    wait_ready(40, 1'b0, t); chk("b3_time", 32'(t), 32'd46);
    wait_ready(20, 1'b0, t); chk("b4_time", 32'(t), 32'd50);

    // Abort after one nibble of byte 5, restart at a new address.
    abort_restart(2, 1'b1, 23'h012345, 2, 1'b1);
    wait_ready(60, 1'b0, t); chk("new_b1_time", 32'(t), 32'd28);
    wait_ready(20, 1'b0, t); chk("new_b2_time", 32'(t), 32'd32);

    // Next transaction is aborted in ADDR while nibble 3 is on the bus.
    abort_restart(0, 1'b1, 23'h055AA1, 0, 1'b0);
    for (int i = 0; i < 10 && (cyc - e0) < 4; i++) @(negedge clk);
    chk("addr_abort_point", 32'(cyc - e0), 32'd4);
    chk("addr_abort_oe_before", 32'(oe), 32'hF);
    // Restart at the top address: byte stream wraps FFFFFE, FFFFFF, 000000.
    abort_restart(0, 1'b1, 23'h7FFFFF, 3, 1'b1);
    wait_ready(60, 1'b0, t); chk("wrap_b1_time", 32'(t), 32'd28);
    wait_ready(20, 1'b0, t);
    wait_ready(20, 1'b0, t);

    // Randomized fetches with random stalls.
    for (int it = 0; it < 8; it++) begin
      a  = 23'($urandom);
      nb = int'($urandom_range(1, 4));
      abort_restart(0, 1'b1, a, nb, 1'b1);
      for (int b = 0; b < nb; b++) wait_ready(400, 1'b1, t);
    end

    // Asynchronous reset in DUMMY, then a repeat of the first fetch.
    abort_restart(0, 1'b1, 23'h000400, 0, 1'b1);
    for (int i = 0; i < 30 && (cyc - e0) < 18; i++) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    start_fetch(23'h000400, 2, 1'b1);
    wait_ready(60, 1'b0, t); chk("rst_b1_time", 32'(t), 32'd28);
    wait_ready(20, 1'b0, t); chk("rst_b2_time", 32'(t), 32'd32);
    abort_restart(0, 1'b0, 23'h0, 0, 1'b0);

    repeat (4) @(negedge clk);
    chk("end_idle_cs_n", 32'(cs_n), 32'h1);
    chk("bytes_outstanding", 32'(exp_byte_q.size()), 32'd0);
    chk("cmds_outstanding", 32'(exp_faddr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
